wb_cmd_master: RTL and testbench

- Wishbone initiator that turns single-word and burst commands from an upstream command/stream interface into classic Wishbone cycles on the internal peripheral bus.
- Its responders are the existing register-mapped slaves, which ack one cycle after accepting and ignore strobes while their ack is high.
- Provides address auto-increment, per-beat write-data flow control, read-data return, and a per-beat ack timeout that aborts a hung cycle.

---
 rtl/wb_cmd_master.sv | 243 ++++++++++++++++++++++++
 tb/tb_wb_cmd_master.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
// ---------------------------------------------------------------------------
// wb_cmd_master
//
// Wishbone classic initiator. It accepts single-word or burst commands from an
// upstream command port and runs them as classic Wishbone cycles on the
// peripheral bus. Addresses auto-increment per beat and wrap at 2^ADDR_WIDTH.
// Write data is taken one beat at a time from a valid/ready stream. Read data
// is returned as one-cycle pulses with no backpressure. If a beat is not acked
// within TIMEOUT cycles of its strobe, the cycle is aborted and reported as an
// error.
//
// Ports
//   clk, rst                  system clock, synchronous active-high reset
//   cmd_valid/cmd_ready       command handshake
//   cmd_we, cmd_adr, cmd_len  direction, start address, beats minus one
//   wdat_valid/wdat_ready     write-word handshake
//   wdat                      write word
//   rsp_valid, rsp_dat        read-word pulse and data
//   rsp_last                  marks the final read beat
//   done, done_err            burst-end pulse; done_err=1 means timeout abort
//   busy                      high from command accept until burst end
//   wb_*_o / wb_*_i           Wishbone classic initiator signals
// ---------------------------------------------------------------------------
// state   | meaning
// --------+------------------------------------------------------------------
// ST_IDLE | bus idle, cmd_ready high, waiting for a command
// ST_WDAT | cyc held, stb low, waiting for the next write word
// ST_STRB | stb high, waiting for ack or for the beat timeout
// ST_DONE | one-cycle bus gap after the burst, busy drops
// ---------------------------------------------------------------------------
module wb_cmd_master #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_adr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,

    input  logic                  wdat_valid,
    output logic                  wdat_ready,
    input  logic [DATA_WIDTH-1:0] wdat,

    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_dat,
    output logic                  rsp_last,

    output logic                  done,
    output logic                  done_err,
    output logic                  busy,

    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    output logic                  wb_we_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    input  logic                  wb_ack_i
);

    // One extra bit so cmd_len = all-ones yields 2^LEN_WIDTH beats.
    localparam int BW = LEN_WIDTH + 1;
    // TIMEOUT is limited to 255, so an 8-bit counter always suffices.
    localparam int TW = 8;
    // Counter value after TIMEOUT-1 ack-less cycles; a missing ack in the
    // following cycle is the one that aborts.
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WDAT = 2'd1,
        ST_STRB = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    state_e                  state_q,     state_d;
    logic [ADDR_WIDTH-1:0]   adr_q,       adr_d;
    logic [DATA_WIDTH-1:0]   dat_q,       dat_d;
    logic                    we_q,        we_d;
    logic                    cyc_q,       cyc_d;
    logic                    stb_q,       stb_d;
    logic [BW-1:0]           beats_q,     beats_d;
    logic [TW-1:0]           tmo_q,       tmo_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_dat_q,   rsp_dat_d;
    logic                    rsp_last_q,  rsp_last_d;
    logic                    done_q,      done_d;
    logic                    done_err_q,  done_err_d;
    logic                    busy_q,      busy_d;

    logic                    last_beat;

    assign last_beat = (beats_q == BW'(1));

    // Handshake readies are pure state decodes, forced low during reset.
    assign cmd_ready  = !rst && (state_q == ST_IDLE);
    assign wdat_ready = !rst && (state_q == ST_WDAT);

    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;
    assign wb_we_o   = we_q;
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = stb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rsp_dat_q;
    assign rsp_last  = rsp_last_q;
    assign done      = done_q;
    assign done_err  = done_err_q;
    assign busy      = busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            adr_q       <= '0;
            dat_q       <= '0;
            we_q        <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            beats_q     <= '0;
            tmo_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_last_q  <= 1'b0;
            done_q      <= 1'b0;
            done_err_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            we_q        <= we_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            beats_q     <= beats_d;
            tmo_q       <= tmo_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_last_q  <= rsp_last_d;
            done_q      <= done_d;
            done_err_q  <= done_err_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        we_d        = we_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        beats_d     = beats_q;
        tmo_d       = tmo_q;
        busy_d      = busy_q;
        rsp_dat_d   = rsp_dat_q;
        // Pulse outputs default low every cycle.
        rsp_valid_d = 1'b0;
        rsp_last_d  = 1'b0;
        done_d      = 1'b0;
        done_err_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    we_d    = cmd_we;
                    adr_d   = cmd_adr;
                    beats_d = BW'(cmd_len) + BW'(1);
                    cyc_d   = 1'b1;
                    busy_d  = 1'b1;
                    tmo_d   = '0;
                    if (cmd_we) begin
                        state_d = ST_WDAT;
                    end else begin
                        stb_d   = 1'b1;
                        state_d = ST_STRB;
                    end
                end
            end

            ST_WDAT: begin
                // No timeout here: a stalled producer keeps the bus owned.
                if (wdat_valid) begin
                    dat_d   = wdat;
                    stb_d   = 1'b1;
                    tmo_d   = '0;
                    state_d = ST_STRB;
                end
            end

            ST_STRB: begin
                // Ack is checked first, so an ack in the final allowed cycle
                // still completes the beat successfully.
                if (wb_ack_i) begin
                    tmo_d   = '0;
                    beats_d = beats_q - BW'(1);
                    if (!we_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_dat_d   = wb_dat_i;
                        rsp_last_d  = last_beat;
                    end
                    if (last_beat) begin
                        cyc_d   = 1'b0;
                        stb_d   = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        adr_d = adr_q + ADDR_WIDTH'(1);
                        // Reads keep stb high: the slave drops ack on this
                        // edge and then sees the next beat's strobe.
                        if (we_q) begin
                            stb_d   = 1'b0;
                            state_d = ST_WDAT;
                        end
                    end
                end else if (tmo_q == TMO_LAST) begin
                    cyc_d      = 1'b0;
                    stb_d      = 1'b0;
                    done_d     = 1'b1;
                    done_err_d = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
module tb_wb_cmd_master;

    localparam int AW = 15;
    localparam int DW = 16;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_we = 1'b0;
    logic [AW-1:0] cmd_adr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          wdat_valid = 1'b0;
    logic          wdat_ready;
    logic [DW-1:0] wdat = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_dat;
    logic          rsp_last;
    logic          done;
    logic          done_err;
    logic          busy;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o;
    logic          wb_we_o;
    logic          wb_cyc_o;
    logic          wb_stb_o;
    logic [DW-1:0] wb_dat_i;
    logic          wb_ack_i;

    always #5 clk = ~clk;

    wb_cmd_master #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .LEN_WIDTH (LW),
        .TIMEOUT   (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_len   (cmd_len),
        .wdat_valid(wdat_valid),
        .wdat_ready(wdat_ready),
        .wdat      (wdat),
        .rsp_valid (rsp_valid),
        .rsp_dat   (rsp_dat),
        .rsp_last  (rsp_last),
        .done      (done),
        .done_err  (done_err),
        .busy      (busy),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_we_o   (wb_we_o),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_dat_i  (wb_dat_i),
        .wb_ack_i  (wb_ack_i)
    );

    // Register-mapped slave: acks one cycle after accepting a strobe and
    // ignores strobes while its ack is high.
    logic          slave_en  = 1'b1;
    logic          force_ack = 1'b0;
    logic [DW-1:0] force_dat = '0;
    logic          s_ack     = 1'b0;
    logic [DW-1:0] s_rdat    = '0;

    function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
        if (a == 15'h0001) return 16'hBEEF;
        return 16'hA000 ^ {1'b0, a};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            s_ack  <= 1'b0;
            s_rdat <= '0;
        end else begin
            s_ack <= slave_en && wb_cyc_o && wb_stb_o && !s_ack;
            if (wb_cyc_o && wb_stb_o && !s_ack) s_rdat <= rd_model(wb_adr_o);
        end
    end

    assign wb_ack_i = s_ack | force_ack;
    assign wb_dat_i = force_ack ? force_dat : s_rdat;

    // Bus and response monitor, sampled on the falling edge.
    logic [AW-1:0] x_adr[$];
    logic [DW-1:0] x_dat[$];
    logic          x_we[$];
    logic [DW-1:0] r_dat[$];
    logic          r_last[$];
    int            done_n = 0;
    int            cyc_n  = 0;
    int            stb_n  = 0;
    int            rise_n = 0;
    logic          prev_cyc = 1'b0;

    always @(negedge clk) begin
        if (rsp_valid) begin
            r_dat.push_back(rsp_dat);
            r_last.push_back(rsp_last);
        end
        if (done) done_n++;
        if (wb_cyc_o) cyc_n++;
        if (wb_stb_o) stb_n++;
        if (wb_cyc_o && !prev_cyc) rise_n++;
        prev_cyc = wb_cyc_o;
        if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
            x_adr.push_back(wb_adr_o);
            x_dat.push_back(wb_we_o ? wb_dat_o : wb_dat_i);
            x_we.push_back(wb_we_o);
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic issue(input logic we, input logic [AW-1:0] adr, input logic [LW-1:0] len);
        int k;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_len   = len;
        cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("cmd_accept", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Returns at the falling edge where done is high.
    task automatic wait_done();
        int k;
        k = 0;
        while (!done && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", 32'(done), 32'd1);
    endtask

    task automatic send_word(input logic [DW-1:0] w);
        int k;
        wdat       = w;
        wdat_valid = 1'b1;
        k = 0;
        while (!wdat_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("wdat_accept", 32'(wdat_ready), 32'd1);
        @(negedge clk);
        wdat_valid = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, rb, c0, s0, d0, r0, k;
        logic [DW-1:0] wd[4];
        logic [AW-1:0] wa[4];
        logic [DW-1:0] ra[4];
        wd = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
        wa = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001};
        ra = '{16'hDFFE, 16'hDFFF, 16'hA000, 16'hBEEF};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cyc",        32'(wb_cyc_o),   32'd0);
        chk("rst_stb",        32'(wb_stb_o),   32'd0);
        chk("rst_busy",       32'(busy),       32'd0);
        chk("rst_cmd_ready",  32'(cmd_ready),  32'd0);
        chk("rst_wdat_ready", 32'(wdat_ready), 32'd0);
        chk("rst_rsp_valid",  32'(rsp_valid),  32'd0);
        chk("rst_done",       32'(done),       32'd0);
        chk("rst_adr",        32'(wb_adr_o),   32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        // Single read
        c0 = cyc_n; r0 = r_dat.size(); d0 = done_n;
        issue(1'b0, 15'h0001, 4'd0);
        chk("rd1_busy", 32'(busy), 32'd1);
        k = 0;
        while (!rsp_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("rd1_latency", 32'(k),        32'd2);
        chk("rd1_dat",     32'(rsp_dat),  32'hBEEF);
        chk("rd1_last",    32'(rsp_last), 32'd1);
        wait_done();
        chk("rd1_err", 32'(done_err), 32'd0);
        repeat (2) @(negedge clk);
        chk("rd1_cyc_cycles", 32'(cyc_n - c0),        32'd2);
        chk("rd1_rsp_count",  32'(r_dat.size() - r0), 32'd1);
        chk("rd1_done_count", 32'(done_n - d0),       32'd1);
        chk("rd1_busy_clr",   32'(busy),              32'd0);

        // 4-beat write with a producer stall before beat 3
        b = x_adr.size(); c0 = rise_n;
        issue(1'b1, 15'h0005, 4'd3);
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                k = 0;
                while (!wdat_ready && k < 50) begin
                    @(negedge clk);
                    k++;
                end
                repeat (3) begin
                    chk("wr_stall_stb", 32'(wb_stb_o), 32'd0);
                    chk("wr_stall_cyc", 32'(wb_cyc_o), 32'd1);
                    @(negedge clk);
                end
            end
            send_word(wd[i]);
        end
        wait_done();
        chk("wr_err", 32'(done_err), 32'd0);
        repeat (2) @(negedge clk);
        chk("wr_xfer_count", 32'(x_adr.size() - b), 32'd4);
        chk("wr_cyc_rises",  32'(rise_n - c0),      32'd1);
        for (int i = 0; i < 4; i++) begin
            if (b + i < x_adr.size()) begin
                chk($sformatf("wr_adr%0d", i), 32'(x_adr[b+i]), 32'(15'h0005 + 15'(i)));
                chk($sformatf("wr_dat%0d", i), 32'(x_dat[b+i]), 32'(wd[i]));
                chk($sformatf("wr_we%0d",  i), 32'(x_we[b+i]),  32'd1);
            end
        end

        // Read burst across the address wrap
        b = x_adr.size(); rb = r_dat.size();
        issue(1'b0, 15'h7FFE, 4'd3);
        wait_done();
        chk("wrap_err", 32'(done_err), 32'd0);
        repeat (2) @(negedge clk);
        chk("wrap_xfer_count", 32'(x_adr.size() - b),  32'd4);
        chk("wrap_rsp_count",  32'(r_dat.size() - rb), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (b + i < x_adr.size())
                chk($sformatf("wrap_adr%0d", i), 32'(x_adr[b+i]), 32'(wa[i]));
            if (rb + i < r_dat.size()) begin
                chk($sformatf("wrap_dat%0d",  i), 32'(r_dat[rb+i]),  32'(ra[i]));
                chk($sformatf("wrap_last%0d", i), 32'(r_last[rb+i]), (i == 3) ? 32'd1 : 32'd0);
            end
        end
        chk("wdat_hold", 32'(wb_dat_o), 32'h0044);

        // Timeout: slave never acks
        slave_en = 1'b0;
        s0 = stb_n; c0 = cyc_n; r0 = r_dat.size();
        issue(1'b0, 15'h0040, 4'd0);
        wait_done();
        chk("tmo_err", 32'(done_err), 32'd1);
        repeat (2) @(negedge clk);
        chk("tmo_stb_cycles", 32'(stb_n - s0),        32'd16);
        chk("tmo_cyc_cycles", 32'(cyc_n - c0),        32'd16);
        chk("tmo_no_rsp",     32'(r_dat.size() - r0), 32'd0);

        // Next command after a timeout is accepted normally
        slave_en = 1'b1;
        r0 = r_dat.size();
        issue(1'b0, 15'h0001, 4'd0);
        wait_done();
        chk("post_tmo_err", 32'(done_err), 32'd0);
        repeat (2) @(negedge clk);
        chk("post_tmo_rsp_count", 32'(r_dat.size() - r0), 32'd1);
        if (r0 < r_dat.size()) chk("post_tmo_dat", 32'(r_dat[r0]), 32'hBEEF);

        // Ack in the 16th strobe cycle still counts as success
        slave_en  = 1'b0;
        force_dat = 16'h1234;
        issue(1'b0, 15'h0010, 4'd0);
        repeat (15) @(negedge clk);
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        chk("edge_done",      32'(done),      32'd1);
        chk("edge_err",       32'(done_err),  32'd0);
        chk("edge_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("edge_rsp_dat",   32'(rsp_dat),   32'h1234);
        chk("edge_rsp_last",  32'(rsp_last),  32'd1);
        repeat (2) @(negedge clk);

        // Reset during beat 2 of a 4-beat read
        slave_en = 1'b1;
        d0 = done_n;
        issue(1'b0, 15'h0020, 4'd3);
        k = 0;
        while (!wb_ack_i && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("mid_first_ack", 32'(wb_ack_i), 32'd1);
        @(negedge clk);
        chk("mid_beat2_stb", 32'(wb_stb_o), 32'd1);
        chk("mid_beat2_adr", 32'(wb_adr_o), 32'h0021);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_cyc",       32'(wb_cyc_o),  32'd0);
        chk("mid_rst_stb",       32'(wb_stb_o),  32'd0);
        chk("mid_rst_busy",      32'(busy),      32'd0);
        chk("mid_rst_done",      32'(done),      32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_post_cmd_ready", 32'(cmd_ready), 32'd1);
        repeat (2) @(negedge clk);
        chk("mid_no_done", 32'(done_n - d0), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
